dbram_pingpong: RTL and testbench

Parametrised double-buffered (ping-pong) memory with an explicit bank-ownership handshake between one producer (write port) and one consumer (read port). The producer fills one bank while the consumer drains the other. Banks swap only when both sides hand them over, so neither side can corrupt or re-read the other's data. It sits between layer-output writers and next-layer operand readers in the accelerator datapaths, in place of free-running toggle double buffers.

---
 rtl/dbram_pingpong_if.sv | 51 +++++
 rtl/dbram_pingpong.sv | 145 ++++++++++++++
 tb/tb_dbram_pingpong.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/dbram_pingpong_if.sv
// Bundle of producer/consumer signals for the ping-pong double-buffered memory.
//
// Producer side: wr_en, wr_addr, wr_data, wr_done in; wr_ready, wr_bank out.
// Consumer side: rd_en, rd_addr, rd_done in; rd_data, rd_data_valid, rd_ready,
// rd_bank out.
// Status: full_count (banks currently FULL), err (sticky protocol violation).
//
// The memory takes the slave modport; the producer/consumer take the master modport.
interface dbram_pingpong_if #(
  parameter int unsigned AWIDTH = 11,
  parameter int unsigned DWIDTH = 60
) ();

  // Producer side
  logic              wr_en;
  logic [AWIDTH-1:0] wr_addr;
  logic [DWIDTH-1:0] wr_data;
  logic              wr_done;
  logic              wr_ready;
  logic              wr_bank;

  // Consumer side
  logic              rd_en;
  logic [AWIDTH-1:0] rd_addr;
  logic [DWIDTH-1:0] rd_data;
  logic              rd_data_valid;
  logic              rd_done;
  logic              rd_ready;
  logic              rd_bank;

  // Status
  logic [1:0]        full_count;
  logic              err;

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_done,
    input  rd_en, rd_addr, rd_done,
    output wr_ready, wr_bank,
    output rd_data, rd_data_valid, rd_ready, rd_bank,
    output full_count, err
  );

  modport master (
    output wr_en, wr_addr, wr_data, wr_done,
    output rd_en, rd_addr, rd_done,
    input  wr_ready, wr_bank,
    input  rd_data, rd_data_valid, rd_ready, rd_bank,
    input  full_count, err
  );

endinterface

// File: rtl/dbram_pingpong.sv
// Double-buffered (ping-pong) memory with an explicit bank-ownership handshake.
//
// One producer fills bank wr_bank while one consumer drains bank rd_bank. Each bank
// is EMPTY or FULL. The producer may only touch an EMPTY bank and hands it over with
// wr_done; the consumer may only read a FULL bank and releases it with rd_done.
// Illegal strobes and out-of-range addresses are dropped and latch the sticky err.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-low reset
//   bus    - dbram_pingpong_if slave modport (producer, consumer and status signals)
//
// Bank contents are not cleared on reset or release.
module dbram_pingpong #(
  parameter int unsigned AWIDTH    = 11,
  parameter int unsigned NUM_WORDS = 2048,
  parameter int unsigned DWIDTH    = 60
) (
  input logic              clk,
  input logic              reset,
  dbram_pingpong_if.slave  bus
);

  // Index width actually needed to address NUM_WORDS entries; never wider than AWIDTH.
  localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  // NUM_WORDS may equal 2^AWIDTH, so compare at AWIDTH+1 bits.
  localparam logic [AWIDTH:0] NumWordsW = (AWIDTH + 1)'(NUM_WORDS);

  typedef enum logic {
    BankEmpty = 1'b0,
    BankFull  = 1'b1
  } bank_state_e;

  // Bank state and ownership pointers
  bank_state_e state_q [2];
  bank_state_e state_d [2];
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic        err_q, err_d;

  // Read output register
  logic [DWIDTH-1:0] rd_data_q;
  logic              rd_valid_q;

  // Storage
  logic [DWIDTH-1:0] mem [2][NUM_WORDS];

  // Handshake decode
  logic            wr_ready, rd_ready;
  logic            wr_addr_ok, rd_addr_ok;
  logic            wr_accept, rd_accept;
  logic            wr_done_accept, rd_done_accept;
  logic            proto_err;
  logic [IdxW-1:0] wr_idx, rd_idx;

  assign wr_ready = (state_q[wr_bank_q] == BankEmpty);
  assign rd_ready = (state_q[rd_bank_q] == BankFull);

  assign wr_addr_ok = ({1'b0, bus.wr_addr} < NumWordsW);
  assign rd_addr_ok = ({1'b0, bus.rd_addr} < NumWordsW);

  assign wr_idx = bus.wr_addr[IdxW-1:0];
  assign rd_idx = bus.rd_addr[IdxW-1:0];

  assign wr_accept      = bus.wr_en & wr_ready & wr_addr_ok;
  assign rd_accept      = bus.rd_en & rd_ready & rd_addr_ok;
  assign wr_done_accept = bus.wr_done & wr_ready;
  assign rd_done_accept = bus.rd_done & rd_ready;

  // Any strobe aimed at a bank the side does not own, or an out-of-range address on
  // an otherwise legal access.
  assign proto_err = (bus.wr_en   & ~wr_ready)
                   | (bus.wr_done & ~wr_ready)
                   | (bus.rd_en   & ~rd_ready)
                   | (bus.rd_done & ~rd_ready)
                   | (bus.wr_en   &  wr_ready & ~wr_addr_ok)
                   | (bus.rd_en   &  rd_ready & ~rd_addr_ok);

  // Next-state logic. When both dones are accepted together they necessarily target
  // different banks (one is EMPTY, the other FULL), so both updates apply.
  always_comb begin
    state_d[0] = state_q[0];
    state_d[1] = state_q[1];
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    err_d      = err_q | proto_err;

    if (wr_done_accept) begin
      state_d[wr_bank_q] = BankFull;
      wr_bank_d          = ~wr_bank_q;
    end

    if (rd_done_accept) begin
      state_d[rd_bank_q] = BankEmpty;
      rd_bank_d          = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q[0] <= BankEmpty;
      state_q[1] <= BankEmpty;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      err_q      <= err_d;
    end
  end

  // Writes use the pre-toggle wr_bank_q, so a write alongside wr_done lands in the
  // bank being handed over.
  always_ff @(posedge clk) begin
    if (reset && wr_accept) begin
      mem[wr_bank_q][wr_idx] <= bus.wr_data;
    end
  end

  // Registered read port; a read alongside rd_done returns the bank being released.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) begin
        rd_data_q <= mem[rd_bank_q][rd_idx];
      end
    end
  end

  assign bus.wr_ready      = wr_ready;
  assign bus.wr_bank       = wr_bank_q;
  assign bus.rd_ready      = rd_ready;
  assign bus.rd_bank       = rd_bank_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_data_valid = rd_valid_q;
  assign bus.full_count    = {1'b0, state_q[0]} + {1'b0, state_q[1]};
  assign bus.err           = err_q;

endmodule

// File: tb/tb_dbram_pingpong.sv
// Directed bench for dbram_pingpong. Reads push their expected word into a queue; a
// monitor pops and compares on every rd_data_valid pulse. Status outputs are checked
// directly from the stimulus thread.
module tb_dbram_pingpong;

  localparam int unsigned AW = 11;
  localparam int unsigned NW = 1000;
  localparam int unsigned DW = 60;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q [$];

  dbram_pingpong_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  dbram_pingpong #(
    .AWIDTH   (AW),
    .NUM_WORDS(NW),
    .DWIDTH   (DW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: rd_data_valid is high for a whole cycle, seen once per negedge.
  always @(negedge clk) begin
    if (bus.rd_data_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got valid with data %0h, expected no valid",
                 bus.rd_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (bus.rd_data !== e) begin
          n_fail++;
          $display("FAIL rd_data: got %0h, expected %0h", bus.rd_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_done = 1'b0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    bus.rd_done = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic done);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_done = done;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    exp_q.push_back(e);
  endtask

  initial begin
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Reset state
    check("rst_wr_ready",   64'(bus.wr_ready),      64'd1);
    check("rst_rd_ready",   64'(bus.rd_ready),      64'd0);
    check("rst_full_count", 64'(bus.full_count),    64'd0);
    check("rst_err",        64'(bus.err),           64'd0);
    check("rst_rd_data",    64'(bus.rd_data),       64'd0);
    check("rst_rd_valid",   64'(bus.rd_data_valid), 64'd0);
    check("rst_wr_bank",    64'(bus.wr_bank),       64'd0);
    check("rst_rd_bank",    64'(bus.rd_bank),       64'd0);

    // Fill bank 0 with A0..A3, hand over on the last write
    for (int i = 0; i < 4; i++) begin
      wr(AW'(i), DW'(60'hA0 + i), (i == 3));
      tick();
    end
    idle();
    check("ho_wr_bank",    64'(bus.wr_bank),    64'd1);
    check("ho_rd_ready",   64'(bus.rd_ready),   64'd1);
    check("ho_full_count", 64'(bus.full_count), 64'd1);
    check("ho_wr_ready",   64'(bus.wr_ready),   64'd1);

    // Back-to-back reads, one-cycle latency
    for (int i = 0; i < 4; i++) begin
      rd(AW'(i), DW'(60'hA0 + i));
      tick();
      check("rd_lat_valid", 64'(bus.rd_data_valid), 64'd1);
    end
    idle();
    tick();
    check("rd_valid_drop", 64'(bus.rd_data_valid), 64'd0);

    // Fill bank 1 without releasing bank 0: both FULL
    wr(11'd0, 60'hB0, 1'b0);
    tick();
    wr(11'd1, 60'hB1, 1'b1);
    tick();
    idle();
    check("both_full_count", 64'(bus.full_count), 64'd2);
    check("both_wr_ready",   64'(bus.wr_ready),   64'd0);
    check("both_err_clean",  64'(bus.err),        64'd0);

    // Write while stalled: flagged and dropped; bank 0 addr 0 must still hold A0
    wr(11'd0, 60'h55, 1'b0);
    tick();
    idle();
    check("stall_wr_err", 64'(bus.err), 64'd1);
    rd(11'd0, 60'hA0);
    tick();
    rd(11'd1, 60'hA1);
    tick();

    // Reset with both banks FULL and a read valid in flight
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mrst_rd_valid",   64'(bus.rd_data_valid), 64'd0);
    check("mrst_rd_data",    64'(bus.rd_data),       64'd0);
    check("mrst_full_count", 64'(bus.full_count),    64'd0);
    check("mrst_wr_ready",   64'(bus.wr_ready),      64'd1);
    check("mrst_rd_ready",   64'(bus.rd_ready),      64'd0);
    check("mrst_err",        64'(bus.err),           64'd0);

    // Same-cycle wr_done (bank 1) and rd_done (bank 0), plus a read of the old bank
    wr(11'd5, 60'hC5, 1'b1);
    tick();
    wr(11'd7, 60'hD7, 1'b1);
    bus.rd_done = 1'b1;
    rd(11'd5, 60'hC5);
    tick();
    idle();
    check("swap_full_count", 64'(bus.full_count), 64'd1);
    check("swap_wr_bank",    64'(bus.wr_bank),    64'd0);
    check("swap_rd_bank",    64'(bus.rd_bank),    64'd1);
    check("swap_err",        64'(bus.err),        64'd0);
    check("swap_wr_ready",   64'(bus.wr_ready),   64'd1);
    check("swap_rd_ready",   64'(bus.rd_ready),   64'd1);
    rd(11'd7, 60'hD7);
    tick();
    idle();
    tick();

    // Out-of-range write: dropped and flagged
    wr(11'd1000, 60'h99, 1'b0);
    tick();
    idle();
    check("oor_wr_err", 64'(bus.err), 64'd1);
    wr(11'd999, 60'hE9, 1'b1);
    tick();
    idle();
    check("oor_full_count", 64'(bus.full_count), 64'd2);
    bus.rd_done = 1'b1;
    tick();
    idle();
    check("oor_rd_bank", 64'(bus.rd_bank), 64'd0);

    // Out-of-range read: no pulse, rd_data holds previous word
    bus.rd_en   = 1'b1;
    bus.rd_addr = 11'd1000;
    tick();
    idle();
    check("oor_rd_valid", 64'(bus.rd_data_valid), 64'd0);
    check("oor_rd_hold",  64'(bus.rd_data),       64'hD7);
    rd(11'd999, 60'hE9);
    tick();
    idle();
    tick();
    tick();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
